// File: rtl/servo_pkg.sv
// servo_pkg: shared types and constants for the servo sweep block.
package servo_pkg;
  localparam int ANGLE_W   = 8;
  localparam int CNT_W     = 8;
  localparam int STEP_DEF  = 4;
  localparam int DWELL_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2
  } state_t;
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts servo periods at the current angle.
// Clear has priority over count; tc flags the last period before dwell ends.
module dwell_counter
  import servo_pkg::*;
#(
  parameter int TERM = DWELL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // period counter, cleared on every entry to dwell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign tc = (count == CNT_W'(TERM - 1));

endmodule

// File: rtl/servo_sweep.sv
// servo_sweep: steps a servo angle back and forth between two bounds,
// dwelling a fixed number of PWM periods at each angle.
// Optional feature: define SERVO_SWEEP_HOLD_EN to add a 'hold' input that
// freezes the dwell count while asserted.
module servo_sweep
  import servo_pkg::*;
#(
  parameter int STEP      = STEP_DEF,
  parameter int DWELL     = DWELL_DEF,
  parameter int ANGLE_MIN = 0,
  parameter int ANGLE_MAX = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cycle_done,
  output logic [ANGLE_W-1:0] angle,
  output logic               dir,
  output logic               settled,
  output logic               sweep_done
`ifdef SERVO_SWEEP_HOLD_EN
  ,
  input  logic               hold
`endif
);

  state_t             state, state_nxt;
  logic               cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0]   cnt;
  logic               settled_nxt, step_en, hold_i, count_ok;
  logic [8:0]         up_sum;
  logic signed [8:0]  dn_diff;
  logic [ANGLE_W-1:0] angle_nxt;
  logic               at_bound;

`ifdef SERVO_SWEEP_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  assign count_ok = cycle_done & ~hold_i;

  dwell_counter #(.TERM(DWELL)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state and counter control; cycle_done only matters in DWELL
  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    settled_nxt = 1'b0;
    step_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (enable) state_nxt = ST_DWELL;
      end
      ST_DWELL: begin
        if (!enable) begin
          // disable wins over a coincident terminating period
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (count_ok && cnt_tc) begin
          state_nxt   = ST_STEP;
          settled_nxt = 1'b1;
          cnt_clr     = 1'b1;
        end else if (count_ok) begin
          cnt_inc = 1'b1;
        end
      end
      ST_STEP: begin
        step_en   = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = enable ? ST_DWELL : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // next angle, clamped to the bound; 9-bit math so nothing wraps
  always_comb begin
    up_sum    = {1'b0, angle} + 9'(STEP);
    dn_diff   = $signed({1'b0, angle}) - $signed(9'(STEP));
    angle_nxt = angle;
    at_bound  = 1'b0;
    if (!dir) begin
      if (up_sum >= 9'(ANGLE_MAX)) begin
        angle_nxt = ANGLE_W'(ANGLE_MAX);
        at_bound  = 1'b1;
      end else begin
        angle_nxt = up_sum[ANGLE_W-1:0];
      end
    end else begin
      if (dn_diff <= $signed(9'(ANGLE_MIN))) begin
        angle_nxt = ANGLE_W'(ANGLE_MIN);
        at_bound  = 1'b1;
      end else begin
        angle_nxt = dn_diff[ANGLE_W-1:0];
      end
    end
  end

  // output registers: angle, direction and the one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle      <= ANGLE_W'(ANGLE_MIN);
      dir        <= 1'b0;
      settled    <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      settled    <= settled_nxt;
      sweep_done <= 1'b0;
      if (step_en) begin
        angle <= angle_nxt;
        if (at_bound) begin
          dir        <= ~dir;
          sweep_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/servo_sweep.md
SERVO_SWEEP -- requirements
Module: servo_sweep

Interface
REQ-001 SHALL have parameter STEP, default 4, angle increment per step (1..255).
REQ-002 SHALL have parameter DWELL, default 2, servo periods held at each angle (1..255).
REQ-003 SHALL have parameter ANGLE_MIN, default 0, lower sweep bound.
REQ-004 SHALL have parameter ANGLE_MAX, default 255, upper sweep bound (greater than ANGLE_MIN).
REQ-005 SHALL have clk  input  1  single system clock; all state on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have enable  input  1  sweep run request, level.
REQ-008 SHALL have cycle_done  input  1  one-cycle pulse from the downstream servo PWM stage at each period start.
REQ-009 SHALL have angle  output  8  commanded angle to the servo PWM stage, registered.
REQ-010 SHALL have dir  output  1  sweep direction; 0 = up, 1 = down.
REQ-011 SHALL have settled  output  1  one-cycle pulse when dwell at the current angle completes; triggers the echo measurement.
REQ-012 SHALL have sweep_done  output  1  one-cycle pulse when a bound is reached.

Function
REQ-013 SHALL implement FSM states IDLE, DWELL, STEP.
REQ-014 IDLE: the FSM SHALL hold angle, and SHALL enter DWELL on the next edge when enable=1, with the dwell counter cleared.
REQ-015 DWELL: each cycle_done pulse SHALL increment the dwell counter.
REQ-016 DWELL: on a cycle_done with counter == DWELL-1, the FSM SHALL assert settled for exactly the next cycle and enter STEP.
REQ-017 DWELL: enable=0 SHALL force IDLE on the next edge, clear the counter, hold angle and suppress settled, including when cycle_done is coincident.
REQ-018 STEP (one cycle), up: the next angle SHALL be min(angle+STEP, ANGLE_MAX), computed at 9 bits with no wrap.
REQ-019 STEP (one cycle), down: the next angle SHALL be max(angle-STEP, ANGLE_MIN), computed signed at 9 bits with no wrap.
REQ-020 STEP: when the new angle equals the bound in the current direction, the block SHALL toggle dir and pulse sweep_done, both registered with the angle update.
REQ-021 STEP SHALL exit to DWELL with the counter cleared if enable=1, else to IDLE.
REQ-022 A cycle_done arriving during STEP or IDLE SHALL be ignored, so the first dwell period after a step is always a full period.
REQ-023 Latency: settled SHALL occur on the cycle after the DWELL-th counted cycle_done; angle SHALL change on the cycle after settled.
REQ-024 settled and sweep_done SHALL never be high for more than one consecutive cycle.

Reset
REQ-025 rst_n low SHALL asynchronously set state=IDLE, angle=ANGLE_MIN, dir=0, dwell counter=0, settled=0, sweep_done=0.
REQ-026 Reset mid-sweep SHALL discard position; after release, the sweep SHALL restart upward from ANGLE_MIN.

Configuration
REQ-027 Macro SERVO_SWEEP_HOLD_EN defined: the block SHALL add input hold (1 bit).
REQ-028 With SERVO_SWEEP_HOLD_EN, while hold=1 in DWELL, cycle_done pulses SHALL NOT be counted and settled SHALL be suppressed; the counter SHALL retain its value and the state SHALL remain unchanged.
REQ-029 Macro undefined: the hold port SHALL be absent, with behaviour identical to hold=0.

Structure
REQ-030 Shared package servo_pkg SHALL hold the FSM state typedef, ANGLE_W=8, and the default STEP/DWELL constants.
REQ-031 Sub-module dwell_counter SHALL implement the counter with clear, count-enable and terminal-count output; the FSM SHALL remain in servo_sweep.

Verification
REQ-032 Scenario: reset, enable=1, DWELL=2, STEP=4, two cycle_done pulses -> settled pulse one cycle after the 2nd pulse; angle 0->4 the following cycle.
REQ-033 Scenario: ANGLE_MAX=255, angle=252, up -> next step gives angle=255, dir=1, sweep_done=1 for one cycle; the following step gives 251.
REQ-034 Scenario: ANGLE_MIN=10, angle=12, down, STEP=4 -> angle=10, dir=0, sweep_done pulse.
REQ-035 Scenario: enable dropped in the same cycle as the terminating cycle_done -> no settled; IDLE; angle unchanged; re-enable requires DWELL fresh pulses.
REQ-036 Scenario: cycle_done pulse during STEP -> not counted; settled only after DWELL further pulses.
REQ-037 Scenario: SERVO_SWEEP_HOLD_EN, hold=1 across 3 cycle_done pulses -> counter frozen, no settled; release -> settled after remaining count; rst_n pulse mid-dwell -> angle=ANGLE_MIN, dir=0 immediately.
